// File: rtl/mat_mult_pkg.sv
// Shared definitions for the matrix-multiply sequencer.
//   DW         : element width (IEEE-754 double bit pattern, carried opaquely)
//   N_DEFAULT  : default matrix dimension
//   seq_state_e: sequencer FSM states
//   elem_off   : bit offset of element [row][col] in a row-major packed matrix
package mat_mult_pkg;

    localparam int DW        = 64;
    localparam int N_DEFAULT = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_ACK,
        S_WAIT_CLR,
        S_COMPLETE
    } seq_state_e;

    function automatic int elem_off(input int row, input int col, input int n, input int dw);
        return (row * n + col) * dw;
    endfunction

endpackage

// File: rtl/mat_lane_select.sv
// One engine lane: picks A[row][M] and B[M][col] out of the captured matrices.
//   a_real/a_imag/b_real/b_imag : captured N*N*DW matrices
//   row, col                    : current job coordinates
//   a_re/a_im/b_re/b_im         : selected lane elements (combinational)
module mat_lane_select #(
    parameter int N  = 3,
    parameter int DW = 64,
    parameter int M  = 0,
    parameter int JW = 5
) (
    input  logic [N*N*DW-1:0] a_real,
    input  logic [N*N*DW-1:0] a_imag,
    input  logic [N*N*DW-1:0] b_real,
    input  logic [N*N*DW-1:0] b_imag,
    input  logic [JW-1:0]     row,
    input  logic [JW-1:0]     col,
    output logic [DW-1:0]     a_re,
    output logic [DW-1:0]     a_im,
    output logic [DW-1:0]     b_re,
    output logic [DW-1:0]     b_im
);
    import mat_mult_pkg::*;

    always_comb begin
        a_re = a_real[elem_off(int'(row), M, N, DW) +: DW];
        a_im = a_imag[elem_off(int'(row), M, N, DW) +: DW];
        b_re = b_real[elem_off(M, int'(col), N, DW) +: DW];
        b_im = b_imag[elem_off(M, int'(col), N, DW) +: DW];
    end

endmodule

// File: rtl/mat_dot_sequencer.sv
// Complex matrix multiply sequencer: captures A and B on go, then issues the
// N*N row-by-column dot products one at a time to an external engine and
// collects each result into C. Handshake per job: valid/start held until
// done, a one-cycle out_read_ack, then wait for the engine to drop done.
//   go, host_ack          : host request / result consumed
//   a_mat_*, b_mat_*      : input matrices, element [i][m] at (i*N+m)*DW
//   busy, result_valid    : status; c_mat_* : result matrix
//   a_*, b_*, valid, start: engine request lanes, lane m at m*DW
//   z_*, done             : engine result; out_read_ack : result taken
//   job_idx               : current job k = i*N+j
module mat_dot_sequencer #(
    parameter int N  = mat_mult_pkg::N_DEFAULT,
    parameter int DW = mat_mult_pkg::DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic [N*N*DW-1:0]      a_mat_real,
    input  logic [N*N*DW-1:0]      a_mat_imag,
    input  logic [N*N*DW-1:0]      b_mat_real,
    input  logic [N*N*DW-1:0]      b_mat_imag,
    output logic                   busy,
    output logic [N*N*DW-1:0]      c_mat_real,
    output logic [N*N*DW-1:0]      c_mat_imag,
    output logic                   result_valid,
    input  logic                   host_ack,
    output logic [N*DW-1:0]        a_real,
    output logic [N*DW-1:0]        a_imag,
    output logic [N*DW-1:0]        b_real,
    output logic [N*DW-1:0]        b_imag,
    output logic                   valid,
    output logic                   start,
    input  logic [DW-1:0]          z_real,
    input  logic [DW-1:0]          z_imag,
    input  logic                   done,
    output logic                   out_read_ack,
    output logic [$clog2(N*N):0]   job_idx
);
    import mat_mult_pkg::*;

    localparam int JOBS = N * N;
    localparam int KW   = $clog2(JOBS);
    localparam int JW   = KW + 1;

    seq_state_e state, state_nx;

    logic [N*N*DW-1:0]      a_re_q, a_im_q, b_re_q, b_im_q;
    logic [N-1:0][DW-1:0]   sel_ar, sel_ai, sel_br, sel_bi;
    logic [N-1:0][DW-1:0]   lane_ar, lane_ai, lane_br, lane_bi;
    logic [JOBS-1:0][DW-1:0] c_re_q, c_im_q;
    logic [JW-1:0]          row, col;

    logic do_cap, do_issue, do_take, do_clr_ack, do_next, do_finish, do_release;

    assign row = job_idx / JW'(N);
    assign col = job_idx % JW'(N);

    for (genvar m = 0; m < N; m++) begin : g_lane
        mat_lane_select #(.N(N), .DW(DW), .M(m), .JW(JW)) u_sel (
            .a_real (a_re_q),
            .a_imag (a_im_q),
            .b_real (b_re_q),
            .b_imag (b_im_q),
            .row    (row),
            .col    (col),
            .a_re   (sel_ar[m]),
            .a_im   (sel_ai[m]),
            .b_re   (sel_br[m]),
            .b_im   (sel_bi[m])
        );
    end

    assign a_real     = lane_ar;
    assign a_imag     = lane_ai;
    assign b_real     = lane_br;
    assign b_imag     = lane_bi;
    assign c_mat_real = c_re_q;
    assign c_mat_imag = c_im_q;

    always_comb begin
        state_nx   = state;
        do_cap     = 1'b0;
        do_issue   = 1'b0;
        do_take    = 1'b0;
        do_clr_ack = 1'b0;
        do_next    = 1'b0;
        do_finish  = 1'b0;
        do_release = 1'b0;
        unique case (state)
            S_IDLE: if (go) begin
                do_cap   = 1'b1;
                state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                do_issue = 1'b1;
                state_nx = S_WAIT_DONE;
            end
            // done is only honoured here, so a stale or early done elsewhere
            // can never write C.
            S_WAIT_DONE: if (done) begin
                do_take  = 1'b1;
                state_nx = S_ACK;
            end
            S_ACK: begin
                do_clr_ack = 1'b1;
                state_nx   = S_WAIT_CLR;
            end
            // Engine holds done past the ack; wait for it to drop so the
            // next job does not see the previous result.
            S_WAIT_CLR: if (!done) begin
                if (job_idx == JW'(JOBS - 1)) begin
                    do_finish = 1'b1;
                    state_nx  = S_COMPLETE;
                end else begin
                    do_next  = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_COMPLETE: if (host_ack) begin
                do_release = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            valid        <= 1'b0;
            start        <= 1'b0;
            out_read_ack <= 1'b0;
            job_idx      <= '0;
            lane_ar      <= '0;
            lane_ai      <= '0;
            lane_br      <= '0;
            lane_bi      <= '0;
            c_re_q       <= '0;
            c_im_q       <= '0;
            a_re_q       <= '0;
            a_im_q       <= '0;
            b_re_q       <= '0;
            b_im_q       <= '0;
        end else begin
            state <= state_nx;
            if (do_cap) begin
                a_re_q  <= a_mat_real;
                a_im_q  <= a_mat_imag;
                b_re_q  <= b_mat_real;
                b_im_q  <= b_mat_imag;
                job_idx <= '0;
                busy    <= 1'b1;
            end
            if (do_issue) begin
                lane_ar <= sel_ar;
                lane_ai <= sel_ai;
                lane_br <= sel_br;
                lane_bi <= sel_bi;
                valid   <= 1'b1;
                start   <= 1'b1;
            end
            if (do_take) begin
                valid                   <= 1'b0;
                start                   <= 1'b0;
                c_re_q[job_idx[KW-1:0]] <= z_real;
                c_im_q[job_idx[KW-1:0]] <= z_imag;
                out_read_ack            <= 1'b1;
            end
            if (do_clr_ack) out_read_ack <= 1'b0;
            if (do_next)    job_idx      <= job_idx + 1'b1;
            if (do_finish)  result_valid <= 1'b1;
            if (do_release) begin
                result_valid <= 1'b0;
                busy         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mat_dot_sequencer.sv
module tb_mat_dot_sequencer;
    localparam int N  = 3;
    localparam int DW = 64;
    localparam int NN = N * N;
    localparam int JW = $clog2(NN) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go = 1'b0;
    logic host_ack = 1'b0;
    logic [NN*DW-1:0] a_mat_real = '0, a_mat_imag = '0, b_mat_real = '0, b_mat_imag = '0;
    logic busy, result_valid, valid, start, out_read_ack;
    logic [NN*DW-1:0] c_mat_real, c_mat_imag;
    logic [N*DW-1:0]  a_real, a_imag, b_real, b_imag;
    logic [DW-1:0]    z_real, z_imag;
    logic             done, eng_done;
    logic             spur_done = 1'b0;
    logic [JW-1:0]    job_idx;

    int n_tests = 0;
    int n_fail  = 0;

    assign done = eng_done | spur_done;

    always #5 clk = ~clk;

    mat_dot_sequencer #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .go(go),
        .a_mat_real(a_mat_real), .a_mat_imag(a_mat_imag),
        .b_mat_real(b_mat_real), .b_mat_imag(b_mat_imag),
        .busy(busy), .c_mat_real(c_mat_real), .c_mat_imag(c_mat_imag),
        .result_valid(result_valid), .host_ack(host_ack),
        .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
        .valid(valid), .start(start), .z_real(z_real), .z_imag(z_imag),
        .done(done), .out_read_ack(out_read_ack), .job_idx(job_idx)
    );

    // ---------------- engine model ----------------
    bit eng_real = 1'b0;
    int hold_cyc = 0;
    int lat      = 2;
    int e_st, e_cnt;

    function automatic logic [2*DW-1:0] calc_z(input logic [N*DW-1:0] ar, ai, br, bi, input bit rmode);
        real sr, si, xa, xai, xb, xbi;
        logic [63:0] tr, ti;
        sr = 0.0; si = 0.0; tr = '0; ti = '0;
        for (int m = 0; m < N; m++) begin
            xa  = $bitstoreal(ar[m*DW +: DW]);
            xai = $bitstoreal(ai[m*DW +: DW]);
            xb  = $bitstoreal(br[m*DW +: DW]);
            xbi = $bitstoreal(bi[m*DW +: DW]);
            sr  = sr + (xa * xb - xai * xbi);
            si  = si + (xa * xbi + xai * xb);
            tr  = tr + ar[m*DW +: DW] * br[m*DW +: DW];
            ti  = ti + (ai[m*DW +: DW] + bi[m*DW +: DW]);
        end
        if (rmode) return {$realtobits(sr), $realtobits(si)};
        return {tr, ti};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            e_st <= 0; e_cnt <= 0; eng_done <= 1'b0; z_real <= '0; z_imag <= '0;
        end else begin
            case (e_st)
                0: if (valid && start) begin
                    {z_real, z_imag} <= calc_z(a_real, a_imag, b_real, b_imag, eng_real);
                    e_cnt <= lat; e_st <= 1;
                end
                1: if (e_cnt == 0) begin eng_done <= 1'b1; e_st <= 2; end
                   else e_cnt <= e_cnt - 1;
                2: if (out_read_ack) begin e_cnt <= hold_cyc; e_st <= 3; end
                3: if (e_cnt == 0) begin eng_done <= 1'b0; e_st <= 0; end
                   else e_cnt <= e_cnt - 1;
                default: e_st <= 0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    typedef struct {
        logic [JW-1:0]   k;
        logic [N*DW-1:0] ar, ai, br, bi;
    } obs_t;
    obs_t obs_q[$];
    int ack_cnt = 0, ack_wide = 0, rv_rise = 0, c_chg = 0;
    logic pv = 1'b0, pa = 1'b0, prv = 1'b0;
    logic [NN*DW-1:0] pc_r = '0, pc_i = '0;

    always @(negedge clk) begin
        if (valid && !pv) obs_q.push_back('{job_idx, a_real, a_imag, b_real, b_imag});
        if (out_read_ack) ack_cnt++;
        if (out_read_ack && pa) ack_wide++;
        if (result_valid && !prv) rv_rise++;
        if (c_mat_real !== pc_r || c_mat_imag !== pc_i) c_chg++;
        pv = valid; pa = out_read_ack; prv = result_valid;
        pc_r = c_mat_real; pc_i = c_mat_imag;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [NN*DW-1:0] r, i;
    } cexp_t;
    cexp_t exp_q[$];

    function automatic cexp_t model_tag(input logic [NN*DW-1:0] ar, ai, br, bi);
        cexp_t e;
        e.r = '0; e.i = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                logic [63:0] sr, si;
                sr = '0; si = '0;
                for (int m = 0; m < N; m++) begin
                    sr = sr + ar[(i*N+m)*DW +: DW] * br[(m*N+j)*DW +: DW];
                    si = si + (ai[(i*N+m)*DW +: DW] + bi[(m*N+j)*DW +: DW]);
                end
                e.r[(i*N+j)*DW +: DW] = sr;
                e.i[(i*N+j)*DW +: DW] = si;
            end
        return e;
    endfunction

    task automatic load_tag(input logic [63:0] ofs);
        for (int i = 0; i < N; i++)
            for (int m = 0; m < N; m++) begin
                a_mat_real[(i*N+m)*DW +: DW] = ofs + 64'(16*i + m);
                a_mat_imag[(i*N+m)*DW +: DW] = ofs + 64'(32'h2000 + 16*i + m);
                b_mat_real[(i*N+m)*DW +: DW] = ofs + 64'(32'h100 + 16*i + m);
                b_mat_imag[(i*N+m)*DW +: DW] = ofs + 64'(32'h3000 + 16*i + m);
            end
        exp_q.push_back(model_tag(a_mat_real, a_mat_imag, b_mat_real, b_mat_imag));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_go();
        go = 1'b1; @(negedge clk); go = 1'b0;
    endtask

    task automatic do_ack();
        host_ack = 1'b1; @(negedge clk); host_ack = 1'b0;
    endtask

    task automatic wait_rv(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (result_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; tick(2);
        n_tests++;
        if ({busy, result_valid, valid, start, out_read_ack} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=00000", {busy, result_valid, valid, start, out_read_ack});
        end
        n_tests++;
        if (job_idx !== '0) begin n_fail++; $display("FAIL reset_job_idx got=%0d exp=0", job_idx); end
        n_tests++;
        if ({a_real, a_imag, b_real, b_imag} !== '0) begin n_fail++; $display("FAIL reset_lanes got=nonzero exp=0"); end
        n_tests++;
        if ({c_mat_real, c_mat_imag} !== '0) begin n_fail++; $display("FAIL reset_c got=nonzero exp=0"); end
        rst = 1'b0; tick(2);
        n_tests++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle got busy=%b valid=%b exp=0 0", busy, valid);
        end
    endtask

    task automatic test_spurious_done();
        int a0;
        a0 = ack_cnt;
        spur_done = 1'b1; tick(4); spur_done = 1'b0; tick(1);
        n_tests++;
        if ({c_mat_real, c_mat_imag} !== '0 || ack_cnt != a0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_done_ignored got acks=%0d busy=%b exp acks=0 busy=0", ack_cnt - a0, busy);
        end
    endtask

    task automatic test_identity();
        int a0, r0;
        bit ok;
        cexp_t e;
        eng_real = 1'b1; hold_cyc = 0;
        for (int k = 0; k < NN; k++) begin
            a_mat_real[k*DW +: DW] = (k / N == k % N) ? 64'h3FF0000000000000 : 64'h0;
            a_mat_imag[k*DW +: DW] = 64'h0;
            b_mat_real[k*DW +: DW] = $realtobits(1.5 * (k + 1) * ((k % 2 != 0) ? -1.0 : 1.0));
            b_mat_imag[k*DW +: DW] = $realtobits(0.25 + k);
        end
        exp_q.push_back('{b_mat_real, b_mat_imag});
        a0 = ack_cnt; r0 = rv_rise;
        pulse_go();
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ident_busy got=%b exp=1", busy); end
        wait_rv(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL ident_timeout got=no result_valid exp=result_valid"); end
        e = exp_q.pop_front();
        n_tests++;
        if (c_mat_real !== e.r || c_mat_imag !== e.i) begin
            n_fail++; $display("FAIL ident_c got=%h exp=%h", c_mat_real, e.r);
        end
        tick(3);
        n_tests++;
        if (ack_cnt - a0 != 9 || rv_rise - r0 != 1) begin
            n_fail++; $display("FAIL ident_pulses got acks=%0d rv=%0d exp acks=9 rv=1", ack_cnt - a0, rv_rise - r0);
        end
        do_ack();
        n_tests++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL ident_release got busy=%b rv=%b exp=0 0", busy, result_valid);
        end
        eng_real = 1'b0;
    endtask

    task automatic test_lanes();
        int o0;
        bit ok;
        cexp_t e;
        logic [N*DW-1:0] ea, eai, eb, ebi, k5a, k5b;
        load_tag(64'h0);
        o0 = obs_q.size();
        pulse_go();
        wait_rv(ok);
        n_tests++;
        if (!ok || obs_q.size() - o0 != 9) begin
            n_fail++; $display("FAIL lanes_issues got=%0d exp=9", obs_q.size() - o0);
        end
        for (int k = 0; k < NN && o0 + k < obs_q.size(); k++) begin
            for (int m = 0; m < N; m++) begin
                ea[m*DW +: DW]  = a_mat_real[((k/N)*N+m)*DW +: DW];
                eai[m*DW +: DW] = a_mat_imag[((k/N)*N+m)*DW +: DW];
                eb[m*DW +: DW]  = b_mat_real[(m*N+(k%N))*DW +: DW];
                ebi[m*DW +: DW] = b_mat_imag[(m*N+(k%N))*DW +: DW];
            end
            n_tests++;
            if (obs_q[o0+k].k !== JW'(k) || obs_q[o0+k].ar !== ea || obs_q[o0+k].ai !== eai ||
                obs_q[o0+k].br !== eb || obs_q[o0+k].bi !== ebi) begin
                n_fail++; $display("FAIL lanes_job%0d got k=%0d a=%h b=%h exp a=%h b=%h",
                                   k, obs_q[o0+k].k, obs_q[o0+k].ar, obs_q[o0+k].br, ea, eb);
            end
        end
        k5a = {64'h12, 64'h11, 64'h10};
        k5b = {64'h122, 64'h112, 64'h102};
        if (obs_q.size() > o0 + 5) begin
            n_tests++;
            if (obs_q[o0+5].ar !== k5a || obs_q[o0+5].br !== k5b) begin
                n_fail++; $display("FAIL lanes_job5_tags got a=%h b=%h exp a=%h b=%h", obs_q[o0+5].ar, obs_q[o0+5].br, k5a, k5b);
            end
        end
        e = exp_q.pop_front();
        n_tests++;
        if (c_mat_real !== e.r || c_mat_imag !== e.i) begin
            n_fail++; $display("FAIL lanes_c got=%h exp=%h", c_mat_real, e.r);
        end
        do_ack();
    endtask

    task automatic test_hold();
        int c0, a0, w0, o0, bad;
        bit ok;
        cexp_t e;
        rst = 1'b1; tick(2); rst = 1'b0; tick(2);
        hold_cyc = 3;
        load_tag(64'h300);
        c0 = c_chg; a0 = ack_cnt; w0 = ack_wide; o0 = obs_q.size();
        pulse_go();
        wait_rv(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL hold_timeout got=no result_valid exp=result_valid"); end
        n_tests++;
        if (c_chg - c0 != 9 || ack_cnt - a0 != 9 || ack_wide != w0) begin
            n_fail++; $display("FAIL hold_counts got cwrites=%0d acks=%0d wide=%0d exp 9 9 0", c_chg - c0, ack_cnt - a0, ack_wide - w0);
        end
        bad = 0;
        for (int k = 0; k < NN; k++)
            if (o0 + k >= obs_q.size() || obs_q[o0+k].k !== JW'(k)) bad++;
        n_tests++;
        if (bad != 0 || obs_q.size() - o0 != 9) begin
            n_fail++; $display("FAIL hold_job_seq got bad=%0d issues=%0d exp bad=0 issues=9", bad, obs_q.size() - o0);
        end
        e = exp_q.pop_front();
        n_tests++;
        if (c_mat_real !== e.r || c_mat_imag !== e.i) begin
            n_fail++; $display("FAIL hold_c got=%h exp=%h", c_mat_real, e.r);
        end
        do_ack();
        hold_cyc = 0;
    endtask

    task automatic test_busy_go();
        int a0, bad;
        bit ok;
        cexp_t e;
        load_tag(64'h50);
        a0 = ack_cnt;
        pulse_go();
        tick(5);
        for (int k = 0; k < NN; k++) a_mat_real[k*DW +: DW] = 64'h777 + 64'(k);
        pulse_go();
        host_ack = 1'b1; tick(1); host_ack = 1'b0;
        wait_rv(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL busy_go_timeout got=no result_valid exp=result_valid"); end
        e = exp_q.pop_front();
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            go = (c == 3);
            if (result_valid !== 1'b1 || busy !== 1'b1 || c_mat_real !== e.r || c_mat_imag !== e.i) bad++;
            tick(1);
        end
        go = 1'b0;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL busy_go_stable got bad_cycles=%0d exp=0", bad); end
        n_tests++;
        if (ack_cnt - a0 != 9) begin n_fail++; $display("FAIL busy_go_restart got acks=%0d exp=9", ack_cnt - a0); end
        go = 1'b1; host_ack = 1'b1; tick(1); go = 1'b0; host_ack = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL go_ack_same got busy=%b rv=%b exp=0 0", busy, result_valid);
        end
        tick(3);
        n_tests++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL go_ack_no_start got busy=%b valid=%b exp=0 0", busy, valid);
        end
    endtask

    task automatic test_reset_mid();
        bit found, ok;
        int a0, o0;
        cexp_t e;
        load_tag(64'h123);
        void'(exp_q.pop_back());
        pulse_go();
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (job_idx == JW'(4) && valid) begin found = 1'b1; break; end
            tick(1);
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL rst_mid_reach got=no job4 exp=job4"); end
        rst = 1'b1; tick(1);
        n_tests++;
        if ({busy, result_valid, valid, start, out_read_ack} !== 5'b0 || job_idx !== '0 ||
            {a_real, a_imag, b_real, b_imag} !== '0 || {c_mat_real, c_mat_imag} !== '0) begin
            n_fail++; $display("FAIL rst_mid_clear got flags=%b k=%0d exp flags=00000 k=0 all zero",
                               {busy, result_valid, valid, start, out_read_ack}, job_idx);
        end
        rst = 1'b0; tick(2);
        load_tag(64'h456);
        a0 = ack_cnt; o0 = obs_q.size();
        pulse_go();
        wait_rv(ok);
        n_tests++;
        if (!ok || ack_cnt - a0 != 9 || obs_q.size() <= o0 || obs_q[o0].k !== '0) begin
            n_fail++; $display("FAIL rst_mid_restart got acks=%0d exp acks=9 from job 0", ack_cnt - a0);
        end
        e = exp_q.pop_front();
        n_tests++;
        if (c_mat_real !== e.r || c_mat_imag !== e.i) begin
            n_fail++; $display("FAIL rst_mid_c got=%h exp=%h", c_mat_real, e.r);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_spurious_done();
        test_identity();
        test_lanes();
        test_hold();
        test_busy_go();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mat_dot_sequencer.md
MAT_DOT_SEQUENCER -- requirements
Module: mat_dot_sequencer

Interface
REQ-001 Parameter: N, 3, matrix dimension; also the engine vector length (engine mat_add_gen).
REQ-002 Parameter: DW, 64, element width (IEEE-754 double bit pattern, never interpreted).
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 go  input  1  host request; capture A and B and start a multiply.
REQ-006 a_mat_real, a_mat_imag  input  N*N*DW each  matrix A; element A[i][m] at bits (i*N+m)*DW +: DW.
REQ-007 b_mat_real, b_mat_imag  input  N*N*DW each  matrix B; same packing.
REQ-008 busy  output  1  high from capture until host_ack accepted.
REQ-009 c_mat_real, c_mat_imag  output  N*N*DW each  result C; C[i][j] at (i*N+j)*DW.
REQ-010 result_valid  output  1  C complete and stable.
REQ-011 host_ack  input  1  host has consumed C.
REQ-012 a_real, a_imag, b_real, b_imag  output  N*DW each  vector lanes to dot-product engine; lane m at m*DW.
REQ-013 valid, start  output  1 each  engine request strobes.
REQ-014 z_real, z_imag  input  DW each  engine dot-product result.
REQ-015 done  input  1  engine result ready; held until after out_read_ack.
REQ-016 out_read_ack  output  1  result consumed acknowledgement to engine.
REQ-017 job_idx  output  $clog2(N*N)+1  current job number k.

Function
REQ-018 States: IDLE, ISSUE, WAIT_DONE, ACK, WAIT_CLR, COMPLETE; all outputs registered.
REQ-019 IDLE: go=1 captures A and B into local storage, job_idx<=0, busy<=1, ->ISSUE next cycle; go in any other state ignored.
REQ-020 Job k = i*N+j, i=k/N, j=k%N, issued in ascending k; N*N jobs per go.
REQ-021 ISSUE (1 cycle): lanes a[m]<=A[i][m], b[m]<=B[m][j] (row i of A, column j of B), valid<=1, start<=1, ->WAIT_DONE.
REQ-022 WAIT_DONE: lanes, valid, start held stable; on done=1: valid<=0, start<=0, C[i][j]<=z, out_read_ack<=1, ->ACK.
REQ-023 ACK (1 cycle): out_read_ack<=0, ->WAIT_CLR; out_read_ack is exactly one cycle wide per job.
REQ-024 WAIT_CLR: remain until done=0 (engine clears done one cycle after ack); then if job_idx=N*N-1 ->COMPLETE with result_valid<=1, else job_idx+1, ->ISSUE.
REQ-025 done high during IDLE, ACK, WAIT_CLR or COMPLETE never records a result.
REQ-026 COMPLETE: result_valid=1, C stable, busy=1; on host_ack=1: result_valid<=0, busy<=0, ->IDLE; go and host_ack in same cycle: ack only.
REQ-027 host_ack outside COMPLETE ignored; no timeout on done.
REQ-028 Minimum per-job latency: ISSUE to next ISSUE = engine latency + 3 cycles.

Reset
REQ-029 rst=1: state IDLE; busy, result_valid, valid, start, out_read_ack, job_idx, all lanes, all C elements <= 0.
REQ-030 rst mid-operation aborts the job; engine shares the same rst; next go restarts at job 0.

Structure
REQ-031 Package mat_mult_pkg holds DW, default N, sequencer state enum, element offset helpers.
REQ-032 One sub-module natural: mat_lane_select (combinational row/column extraction by i, j); engine instantiated at parent level, not inside.

Verification
REQ-033 A=identity (diag 0x3FF0000000000000, imag 0), B arbitrary, real engine -> C=B, 9 out_read_ack pulses, result_valid once.
REQ-034 Stub engine, A[i][m]=tag 0x10*i+m, B[m][j]=0x100+0x10*m+j; at job 5 -> a lanes 0x10,0x11,0x12; b lanes 0x102,0x112,0x122.
REQ-035 Stub holds done 3 cycles after ack -> one C write per job, job_idx increments once.
REQ-036 go pulsed while busy; host_ack delayed 10 cycles -> no restart, result_valid and C stable until ack.
REQ-037 rst during job 4 -> all outputs 0 next cycle; subsequent go yields correct full C from job 0.
